fp_square: RTL

- Sequential IEEE-754 single-precision squarer: result = A*A. It is the inverse companion of the sqrt unit.
- Used to check sqrt results by re-squaring them.
- Also used as the x*x step in iterative refinement on the same FP datapath.
- Interface is a start/done handshake with a shift-add mantissa multiplier; one operand in, one result out.

---
 rtl/fp_square.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fp_square.sv
// Sequential IEEE-754 single-precision squarer (Out = A*A) with a shift-add mantissa multiplier.
// Latency: done pulses ITER+2 cycles after the accepted start; optional macro FP_SQUARE_SUBNORMAL_EN enables gradual underflow.
// Backpressure: none; start is ignored unless idle, Out holds until the next accepted start.
module fp_square #(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    output logic        busy,
    output logic        done,
    output logic [31:0] Out
);
    localparam int ITER = 24 / RADIX_BITS;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
    typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

    state_t      state;
    kind_t       kind;
    logic [4:0]  cnt;
    logic [7:0]  ea;
    logic [47:0] acc;
    logic [47:0] mcand_sh;
    logic [23:0] mplier;
    logic [47:0] pp;
    logic [31:0] res;
    logic [31:0] norm_res;
    logic [23:0] a_mant;
    logic        a_sign_unused;

    // Operand sign never matters for a square.
    assign a_sign_unused = A[31];
    assign a_mant        = (A[30:23] == 8'd0) ? 24'd0 : {1'b1, A[22:0]};

    always_comb begin
        pp = '0;
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (mplier[j]) pp = pp + (mcand_sh << j);
        end
    end

    logic               norm_bit;
    logic [45:0]        fr;
    logic               sticky0;
    logic signed [9:0]  exp_s;
    logic [22:0]        frac;
    logic               g_bit;
    logic               s_bit;
    logic               rnd;
    logic [30:0]        mag;
`ifdef FP_SQUARE_SUBNORMAL_EN
    logic [4:0]         sh;
    logic [69:0]        wide_sh;
    logic               sub_g;
    logic               sub_s;
    logic               sub_rnd;
    logic [30:0]        sub_mag;
`endif

    always_comb begin
        norm_bit = acc[47];
        fr       = norm_bit ? acc[46:1] : acc[45:0];
        sticky0  = norm_bit & acc[0];
        exp_s    = $signed({1'b0, ea, 1'b0}) - 10'sd127 + $signed({9'd0, norm_bit});
        frac     = fr[45:23];
        g_bit    = fr[22];
        s_bit    = (|fr[21:0]) | sticky0;
        rnd      = g_bit & (s_bit | frac[0]);
        // Adding the round bit across the packed exponent lets a mantissa carry bump E.
        mag      = {exp_s[7:0], frac} + {30'd0, rnd};
`ifdef FP_SQUARE_SUBNORMAL_EN
        sh       = 5'(10'sd1 - exp_s);
        wide_sh  = {1'b1, fr, 23'd0} >> sh;
        sub_g    = wide_sh[45];
        sub_s    = (|wide_sh[44:0]) | sticky0;
        sub_rnd  = sub_g & (sub_s | wide_sh[46]);
        // Bit 69 is the hidden-bit slot, always zero after a shift of at least one.
        sub_mag  = {7'd0, wide_sh[69:46]} + {30'd0, sub_rnd};
`endif
        case (kind)
            K_NAN:   norm_res = 32'h7fc0_0000;
            K_INF:   norm_res = 32'h7f80_0000;
            K_ZERO:  norm_res = 32'h0000_0000;
            default: begin
                if (exp_s >= 10'sd255) begin
                    norm_res = 32'h7f80_0000;
                end else if (exp_s <= 10'sd0) begin
`ifdef FP_SQUARE_SUBNORMAL_EN
                    norm_res = (exp_s >= -10'sd23) ? {1'b0, sub_mag} : 32'h0000_0000;
`else
                    norm_res = 32'h0000_0000;
`endif
                end else if (mag[30:23] == 8'hff) begin
                    norm_res = 32'h7f80_0000;
                end else begin
                    norm_res = {1'b0, mag};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            kind     <= K_ZERO;
            busy     <= 1'b0;
            done     <= 1'b0;
            Out      <= 32'h0;
            res      <= 32'h0;
            cnt      <= 5'd0;
            ea       <= 8'd0;
            acc      <= 48'd0;
            mcand_sh <= 48'd0;
            mplier   <= 24'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ea       <= A[30:23];
                        acc      <= 48'd0;
                        cnt      <= 5'd0;
                        mcand_sh <= {24'd0, a_mant};
                        mplier   <= a_mant;
                        busy     <= 1'b1;
                        state    <= MUL;
                        if (A[30:23] == 8'hff)
                            kind <= (A[22:0] != 23'd0) ? K_NAN : K_INF;
                        else if (A[30:23] == 8'd0)
                            kind <= K_ZERO;
                        else
                            kind <= K_NUM;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                MUL: begin
                    acc      <= acc + pp;
                    mcand_sh <= mcand_sh << RADIX_BITS;
                    mplier   <= mplier >> RADIX_BITS;
                    cnt      <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) state <= NORM;
                end
                NORM: begin
                    res   <= norm_res;
                    state <= DONE;
                end
                DONE: begin
                    Out   <= res;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
